// File: rtl/eth_rx_arbiter.sv
// Two-source round-robin packet arbiter feeding packet_decoder.
// Packets are never interleaved; over-length packets are cut and the tail drained.
module eth_rx_arbiter #(
  parameter int DW = 32,
  parameter int KW = DW / 8,
  parameter int BW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s0_data,
  input  logic [DW-1:0] s1_data,
  input  logic          s0_valid,
  input  logic          s1_valid,
  input  logic          s0_last,
  input  logic          s1_last,
  input  logic [KW-1:0] s0_keep,
  input  logic [KW-1:0] s1_keep,
  output logic          s0_ready,
  output logic          s1_ready,
  input  logic [1:0]    port_en,
  input  logic [BW-1:0] max_beats,
  output logic [DW-1:0] packet4_byte,
  output logic          data_valid,
  output logic          last_valid,
  output logic [KW-1:0] keep,
  output logic [1:0]    grant,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1,
  output logic          trunc_err
);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rr_last;
  logic [BW-1:0] r_beats;
  logic [DW-1:0] r_data;
  logic [KW-1:0] r_keep;
  logic          r_dv, r_lv, r_trunc;
  logic [CW-1:0] r_pkt_cnt0, r_pkt_cnt1;

  logic [1:0]    w_req;
  logic          w_sel, w_in_grant, w_in_drain;
  logic          w_valid, w_last, w_acc, w_fwd, w_trunc;
  logic [DW-1:0] w_data;
  logic [KW-1:0] w_keep;
  logic [BW-1:0] w_beats_nxt;

  assign w_req      = {s1_valid & port_en[1], s0_valid & port_en[0]};
  assign w_sel      = (r_state == GRANT1) || (r_state == DRAIN1);
  assign w_in_grant = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_in_drain = (r_state == DRAIN0) || (r_state == DRAIN1);

  assign s0_ready = (r_state == GRANT0) || (r_state == DRAIN0);
  assign s1_ready = (r_state == GRANT1) || (r_state == DRAIN1);

  assign w_valid = w_sel ? s1_valid : s0_valid;
  assign w_last  = w_sel ? s1_last  : s0_last;
  assign w_data  = w_sel ? s1_data  : s0_data;
  assign w_keep  = w_sel ? s1_keep  : s0_keep;

  assign w_acc       = (w_in_grant | w_in_drain) & w_valid;
  assign w_fwd       = w_in_grant & w_valid;
  assign w_beats_nxt = r_beats + BW'(1);
  // A real last beat landing exactly on the limit is a normal end, not a cut.
  assign w_trunc     = w_fwd & ~w_last & (max_beats != '0) & (w_beats_nxt == max_beats);

  always_comb begin
    w_state_nxt = r_state;
    grant       = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (w_req == 2'b11)  w_state_nxt = r_rr_last ? GRANT0 : GRANT1;
        else if (w_req[0])   w_state_nxt = GRANT0;
        else if (w_req[1])   w_state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        grant = w_sel ? 2'b10 : 2'b01;
        if (w_acc & w_last) w_state_nxt = IDLE;
        else if (w_trunc)   w_state_nxt = w_sel ? DRAIN1 : DRAIN0;
      end
      DRAIN0, DRAIN1: begin
        grant = w_sel ? 2'b10 : 2'b01;
        if (w_acc & w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_last  <= 1'b1;
      r_beats    <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_dv       <= 1'b0;
      r_lv       <= 1'b0;
      r_trunc    <= 1'b0;
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt != IDLE) begin
        r_rr_last <= (w_state_nxt == GRANT1);
        r_beats   <= '0;
      end else if (w_fwd) begin
        r_beats <= w_beats_nxt;
      end
      r_dv    <= w_fwd;
      r_lv    <= w_fwd & (w_last | w_trunc);
      r_trunc <= w_trunc;
      if (w_fwd) begin
        r_data <= w_data;
        r_keep <= w_trunc ? {KW{1'b1}} : w_keep;
      end
      if (w_fwd & (w_last | w_trunc)) begin
        if (w_sel) r_pkt_cnt1 <= r_pkt_cnt1 + CW'(1);
        else       r_pkt_cnt0 <= r_pkt_cnt0 + CW'(1);
      end
    end
  end

  assign packet4_byte = r_data;
  assign data_valid   = r_dv;
  assign last_valid   = r_lv;
  assign keep         = r_keep;
  assign trunc_err    = r_trunc;
  assign pkt_cnt0     = r_pkt_cnt0;
  assign pkt_cnt1     = r_pkt_cnt1;

endmodule

// File: doc/eth_rx_arbiter.md
ETH_RX_ARBITER -- requirements
Module: eth_rx_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have ports s0_data / s1_data, input, 32 bits: source beat, first byte in [31:24].
REQ-004 SHALL have ports s0_valid / s1_valid, input, 1 bit each: source beat valid.
REQ-005 SHALL have ports s0_last / s1_last, input, 1 bit each: last beat of the packet.
REQ-006 SHALL have ports s0_keep / s1_keep, input, 4 bits each: byte enables, meaningful on last beat.
REQ-007 SHALL have ports s0_ready / s1_ready, output, 1 bit each: beat accepted when valid & ready.
REQ-008 SHALL have port port_en, input, 2 bits: per-source request enable (bit n = source n).
REQ-009 SHALL have port max_beats, input, 12 bits: packet length limit in beats, 0 = unlimited.
REQ-010 SHALL have ports packet4_byte (32), data_valid (1), last_valid (1), keep (4), outputs: stream to packet_decoder.
REQ-011 SHALL have port grant, output, 2 bits: one-hot owner of the current packet, 0 when idle.
REQ-012 SHALL have ports pkt_cnt0 / pkt_cnt1, output, 16 bits each: packets forwarded per source.
REQ-013 SHALL have port trunc_err, output, 1 bit: one-cycle pulse on a truncated packet.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1.
REQ-015 IDLE: request n = sn_valid & port_en[n]; single request -> GRANTn; both -> source != rr_last; none -> stay.
REQ-016 On entry to GRANTn, rr_last SHALL be set to n.
REQ-017 sn_ready SHALL equal 1 only in GRANTn or DRAINn (combinational from state); otherwise 0.
REQ-018 In GRANTn each accepted beat SHALL appear on the output one cycle later: packet4_byte=sn_data, data_valid=1, last_valid=sn_last, keep=sn_keep.
REQ-019 data_valid SHALL be 0 in any cycle following no accepted beat in GRANTn; packet4_byte/keep hold their last values.
REQ-020 An accepted beat with sn_last=1 SHALL move GRANTn -> IDLE; minimum one idle cycle between packets.
REQ-021 A 12-bit beat counter SHALL count accepted beats of the current packet, clearing on entry to GRANTn.
REQ-022 If max_beats != 0, the accepted beat making count == max_beats with sn_last=0 SHALL be output with last_valid=1, keep=4'hF; trunc_err pulses with that output beat; state -> DRAINn.
REQ-023 DRAINn SHALL accept and discard beats (data_valid=0) until a beat with sn_last=1 is accepted, then -> IDLE.
REQ-024 A beat with sn_last=1 that also reaches max_beats SHALL be treated as normal last; no truncation.
REQ-025 Deasserting port_en[n] in GRANTn/DRAINn SHALL NOT abort; the packet completes normally.
REQ-026 pkt_cntn SHALL increment by 1 when an output beat with last_valid=1 from source n is emitted (truncated included), wrapping 16'hFFFF -> 0.
REQ-027 grant SHALL be 2'b01 in GRANT0/DRAIN0, 2'b10 in GRANT1/DRAIN1, 2'b00 in IDLE.
REQ-028 max_beats changes SHALL take effect at the next beat compare; no restart.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, rr_last=1 (source 0 wins first tie), beat counter 0, all outputs 0 including pkt_cnt0/1 and packet4_byte.
REQ-030 Reset mid-packet SHALL drop the packet; after release a source mid-packet is handled as a new packet at its next valid beat.

Verification
REQ-031 Source 0 only, port_en=2'b01, 4-beat packet 32'hA1AAAAAA..32'h12345678, keep=4'b0011 -> identical 4 beats out 1 cycle later, last_valid on 4th, keep=4'b0011, pkt_cnt0=1, grant=01 during packet.
REQ-032 Both sources valid continuously with 3-beat packets, port_en=2'b11 -> packet order 0,1,0,1; one IDLE cycle between packets; no interleaving of beats.
REQ-033 max_beats=3, source 1 sends 6-beat packet -> 3 beats out, 3rd with last_valid=1 keep=4'hF, trunc_err pulse same cycle, beats 4-6 consumed with data_valid=0, pkt_cnt1=1.
REQ-034 max_beats=4 with 4-beat packet -> no trunc_err, keep from source.
REQ-035 Source 0 valid gaps mid-packet and port_en[0] cleared at beat 2 -> data_valid follows gaps, packet completes, then source 0 not granted.
REQ-036 rst low at beat 2 of a source-0 packet -> all outputs 0 immediately; after release with both valid, source 0 granted first; pkt_cnt0 preset 16'hFFFF via 65535 packets (or force) wraps to 0.
